// File: rtl/mc_control.sv
// mc_control: control unit for a multicycle MIPS datapath.
// A Moore FSM steps each instruction through fetch, decode, execute, memory
// and writeback, and drives the shared-datapath muxes and enables.
// Supported instructions: R-type, lw, sw, beq, bne, addi and j.
//
// Optional feature, selected by the macro MC_ILLEGAL_TRAP_EN:
//   defined   - an unknown opcode parks the FSM in TRAP and sets the sticky
//               illegal flag; only reset leaves TRAP.
//   undefined - an unknown opcode retires as a two-cycle NOP and illegal is
//               tied to 0.
//
// Ports:
//   clk, rst_n        clock (rising edge) and async active-low reset
//   start             leaves IDLE and begins fetching
//   opcode            instruction bits [31:26], sampled in DECODE
//   mem_ready         memory completes the current read or write this cycle
//   alu_zero          ALU zero flag
//   pc_en ... pc_source  datapath controls
//   instr_done        pulse in the last cycle of each instruction
//   instr_count       retired-instruction count (wraps)
//   illegal           sticky illegal-opcode flag
module mc_control #(
    parameter int          CNT_W    = 32,
    parameter logic [5:0]  OP_RTYPE = 6'h00,
    parameter logic [5:0]  OP_LW    = 6'h23,
    parameter logic [5:0]  OP_SW    = 6'h2B,
    parameter logic [5:0]  OP_BEQ   = 6'h04,
    parameter logic [5:0]  OP_BNE   = 6'h05,
    parameter logic [5:0]  OP_ADDI  = 6'h08,
    parameter logic [5:0]  OP_J     = 6'h02
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    input  logic             alu_zero,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_RTEX   = 4'd7;
    localparam logic [3:0] S_RTWB   = 4'd8;
    localparam logic [3:0] S_ADDIWB = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
`ifdef MC_ILLEGAL_TRAP_EN
    localparam logic [3:0] S_TRAP   = 4'd12;
`endif

    logic [3:0]       state_r;
    logic [3:0]       next_s;
    logic [5:0]       op_r;
    logic [CNT_W-1:0] count_r;
    logic             pc_write_s;
    logic             pc_write_cond_s;
    logic             branch_ne_s;
    logic             done_s;

    // Next-state and Moore output decode; unlisted controls stay 0.
    always_comb begin
        next_s          = state_r;
        pc_write_s      = 1'b0;
        pc_write_cond_s = 1'b0;
        iord            = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        ir_write        = 1'b0;
        reg_write       = 1'b0;
        reg_dst         = 1'b0;
        mem_to_reg      = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        alu_op          = 2'b00;
        pc_source       = 2'b00;
        done_s          = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_s = S_FETCH;
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_FETCH: begin
                // PC+4 is computed every cycle but only committed with the IR.
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                ir_write   = mem_ready;
                pc_write_s = mem_ready;
                if (mem_ready) begin
                    next_s = S_DECODE;
                end else begin
                    next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW, OP_ADDI: next_s = S_MEMADR;
                    OP_RTYPE:              next_s = S_RTEX;
                    OP_BEQ, OP_BNE:        next_s = S_BRANCH;
                    OP_J:                  next_s = S_JUMP;
                    default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                        next_s = S_TRAP;
`else
                        next_s = S_FETCH;
                        done_s = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op_r)
                    OP_LW:   next_s = S_MEMRD;
                    OP_SW:   next_s = S_MEMWR;
                    default: next_s = S_ADDIWB;
                endcase
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    next_s = S_MEMWB;
                end else begin
                    next_s = S_MEMRD;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                done_s     = 1'b1;
                next_s     = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    next_s = S_FETCH;
                    done_s = 1'b1;
                end else begin
                    next_s = S_MEMWR;
                end
            end
            S_RTEX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                next_s    = S_RTWB;
            end
            S_RTWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                done_s    = 1'b1;
                next_s    = S_FETCH;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                done_s    = 1'b1;
                next_s    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a       = 1'b1;
                alu_op          = 2'b01;
                pc_source       = 2'b01;
                pc_write_cond_s = 1'b1;
                done_s          = 1'b1;
                next_s          = S_FETCH;
            end
            S_JUMP: begin
                pc_write_s = 1'b1;
                pc_source  = 2'b10;
                done_s     = 1'b1;
                next_s     = S_FETCH;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP: begin
                next_s = S_TRAP;
            end
`endif
            default: begin
                next_s = S_IDLE;
            end
        endcase
    end

    // bne inverts the sense of the zero flag for the conditional PC write.
    assign branch_ne_s = (op_r == OP_BNE);
    assign pc_en       = pc_write_s | (pc_write_cond_s & (alu_zero ^ branch_ne_s));
    assign instr_done  = done_s;
    assign instr_count = count_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Opcode latch; later states decode the copy taken in DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= 6'h00;
        end else if (state_r == S_DECODE) begin
            op_r <= opcode;
        end
    end

    // Retired-instruction counter, wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (done_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic illegal_r;

    // Sticky illegal flag, raised together with entry into TRAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else if (next_s == S_TRAP) begin
            illegal_r <= 1'b1;
        end
    end

    assign illegal = illegal_r;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle MIPS control unit. Moore-style FSM that steps each instruction through fetch, decode, execute, memory and writeback cycles, and drives the shared-datapath multiplexers and enables. Supports R-type, lw, sw, beq, bne, addi and j. Memory accesses stall on a `mem_ready` handshake, and retired instructions are counted. It replaces the single-cycle opcode decoder in front of the multicycle datapath.

## Interface
Parameters:
- `CNT_W`, 32: width of the retired-instruction counter.
- `OP_RTYPE` 6'h00, `OP_LW` 6'h23, `OP_SW` 6'h2B, `OP_BEQ` 6'h04, `OP_BNE` 6'h05, `OP_ADDI` 6'h08, `OP_J` 6'h02: opcode encodings.

Ports:
- `clk` in 1: clock. One clock domain only, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: leaves IDLE and begins fetching.
- `opcode` in 6: instruction register bits [31:26]. Sampled in DECODE.
- `mem_ready` in 1: memory completes the current read or write this cycle.
- `alu_zero` in 1: ALU zero flag.
- `pc_en` out 1: `pc_write | (pc_write_cond & (alu_zero ^ branch_ne))`.
- `iord` out 1: memory address select (0 = PC, 1 = ALUOut).
- `mem_read`, `mem_write`, `ir_write`, `reg_write`, `reg_dst`, `mem_to_reg`, `alu_src_a` out 1 each: datapath controls.
- `alu_src_b` out 2: ALU B select (00 = reg B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate).
- `alu_op` out 2: ALU operation (00 = add, 01 = sub, 10 = funct).
- `pc_source` out 2: PC source (00 = ALU, 01 = ALUOut, 10 = jump target).
- `instr_done` out 1: one-cycle pulse in the last cycle of each instruction.
- `instr_count` out CNT_W: retired-instruction count.
- `illegal` out 1: sticky illegal-opcode flag.

## Operation
- State is a 4-bit register. States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, RTWB, ADDIWB, BRANCH, JUMP, TRAP.
- Outputs are decoded from state. Exceptions: `ir_write` and `pc_en` in FETCH are gated by `mem_ready`; `pc_en` depends on `alu_zero`. Any control not listed for a state is 0.
- IDLE: all outputs 0. Goes to FETCH when `start`=1.
- FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Holds while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target into ALUOut). Next state by opcode:
  - lw, sw, addi: MEMADR.
  - R-type: RTEX.
  - beq, bne: BRANCH.
  - j: JUMP.
  - other opcodes: see Configuration.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. lw goes to MEMRD, sw to MEMWR, addi to ADDIWB.
- MEMRD: `mem_read`=1, `iord`=1. Holds until `mem_ready`, then MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Goes to FETCH.
- MEMWR: `mem_write`=1, `iord`=1. Holds until `mem_ready`, then FETCH.
- RTEX: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Goes to RTWB.
- RTWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Goes to FETCH.
- ADDIWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Goes to FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_source`=01, `pc_write_cond`=1. Internal `branch_ne` = (opcode == OP_BNE). Goes to FETCH.
- JUMP: `pc_write`=1, `pc_source`=10. Goes to FETCH.
- `instr_done`=1 in any state whose next state is FETCH. In MEMWR it is asserted only in the `mem_ready` cycle.
- `instr_count` increments on the clock edge that ends an `instr_done` cycle. It wraps modulo 2^CNT_W silently.
- `opcode` is latched into an internal register in DECODE. Later states use the latched copy.

## Timing
- Reset (asynchronous, any state, mid-instruction included): state → IDLE, `instr_count` → 0, `illegal` → 0, all outputs 0.
- A write or memory request in progress at reset is abandoned. No completion pulse is generated.
- Latency with zero wait states, counting the FETCH cycle:
  - lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3.
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds one cycle.
- `mem_read`/`mem_write` stay asserted and `iord` stays stable for the whole wait.
- `mem_ready` outside FETCH, MEMRD and MEMWR is ignored.
- `start` outside IDLE is ignored.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined:
  - An unrecognised opcode in DECODE goes to TRAP.
  - TRAP sets `illegal`=1 and drives all controls 0. No `instr_done`, no count.
  - TRAP is left only by reset.
- `MC_ILLEGAL_TRAP_EN` undefined:
  - An unrecognised opcode is a 2-cycle NOP: DECODE goes to FETCH with `instr_done`=1 and the count increments.
  - `illegal` is tied to 0. There is no TRAP state.

## Test plan
- Reset, `start`=1, lw with `mem_ready`=1 always → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; `reg_write`=1 with `mem_to_reg`=1 in cycle 5; `instr_count`=1.
- lw with `mem_ready` low for 3 cycles in FETCH and 2 cycles in MEMRD → 10 cycles total; `ir_write` high only in the ready cycle; `mem_read` held throughout the waits.
- beq with `alu_zero`=1 → `pc_en`=1 in BRANCH. Same with `alu_zero`=0 → `pc_en`=0. bne → the inverse of both.
- R-type then j → RTEX `alu_op`=10, RTWB `reg_dst`=1; JUMP `pc_source`=10 with `pc_en`=1; `instr_done` pulsed twice; count 2.
- Opcode 6'h3F → with `MC_ILLEGAL_TRAP_EN`: `illegal`=1 and the FSM is stuck in TRAP with outputs 0. Without: a NOP, back in FETCH after 2 cycles, count +1.
- Deassert `rst_n` in MEMWR while `mem_ready`=0 → `mem_write` drops immediately; count 0; IDLE until `start`.
